shift_seq_ctrl: RTL
===================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the shifter datapath width; only 32 is supported.
REQ-002 The block SHALL have parameter SHAMT_W, default 5, meaning the shift-amount width, with WIDTH = 2**SHAMT_W.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request a shift operation; sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 ROTL; captured with start.
REQ-007 The block SHALL have port shamt, input, SHAMT_W bits: shift count 0..31; captured with start.
REQ-008 The block SHALL have port din, input, WIDTH bits: operand; captured with start.
REQ-009 The block SHALL have port busy, output, 1 bit: high in LOAD and SHIFT.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse in DONE.
REQ-011 The block SHALL have port result, output, WIDTH bits: last completed result; held until the next DONE.
REQ-012 The block SHALL have ports sh_s1 and sh_s0, outputs, 1 bit each: mode select to the 74LS194-style 32-bit shifter (00 hold, 01 shift right, 10 shift left, 11 parallel load).
REQ-013 The block SHALL have ports sh_sl and sh_sr, outputs, 1 bit each: serial-in at bit 0 (left shift) and at bit 31 (right shift).
REQ-014 The block SHALL have port sh_clear, output, 1 bit: active-high clear to the shifter.
REQ-015 The block SHALL have port sh_pdata, output, WIDTH bits: parallel-load data to the shifter.
REQ-016 The block SHALL have port sh_q, input, WIDTH bits: shifter register contents.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, LOAD, SHIFT, DONE.
REQ-018 IDLE transitions: start=1 -> LOAD and captures op, shamt and din; start=0 -> stays in IDLE.
REQ-019 LOAD SHALL drive sh_s1/sh_s0=11 with sh_pdata = captured din, for exactly one cycle.
REQ-020 LOAD SHALL go to DONE if shamt=0 and to SHIFT otherwise, with the down-counter set to shamt.
REQ-021 SHIFT SHALL issue one 1-bit shift per cycle for exactly shamt cycles, decrementing the counter each cycle, then go to DONE.
REQ-022 SLL SHALL use mode 10 with sh_sl=0.
REQ-023 ROTL SHALL use mode 10 with sh_sl=sh_q[31].
REQ-024 SRL SHALL use mode 01 with sh_sr=0.
REQ-025 SRA SHALL use mode 01 with sh_sr=sh_q[31].
REQ-026 In IDLE and DONE the shifter mode SHALL be 00 (hold), and sh_sl, sh_sr and sh_pdata SHALL be 0 outside their use.
REQ-027 DONE SHALL register result<=sh_q, pulse done=1, and return to IDLE next cycle.
REQ-028 Latency SHALL be fixed: start sampled at edge N -> done high in cycle N+shamt+2.
REQ-029 start while busy or in DONE SHALL be ignored; it is neither queued nor allowed to alter captured operands.
REQ-030 Counter arithmetic SHALL be unsigned SHAMT_W bits, and the counter SHALL never wrap below 0.

Reset
REQ-031 rst=1 at any edge, including mid-SHIFT, SHALL force IDLE, busy=0, done=0, result=0, counter=0, and captured operands=0.
REQ-032 sh_clear SHALL equal rst combinationally; it SHALL be 0 otherwise.
REQ-033 An operation aborted by reset SHALL produce no done pulse.

Structure
REQ-034 Package shift_ctrl_pkg SHALL hold the op encodings, the FSM state enum, and the shifter mode constants (HOLD, SHR, SHL, LOAD).
REQ-035 One sub-module, shift_cnt (loadable SHAMT_W-bit down-counter with zero flag), SHALL be instantiated; everything else stays in shift_seq_ctrl.
REQ-036 The bench SHALL pair the block with the existing 32-bit 74LS194-based shifter, with sh_clear wired to its clear input.

Verification
REQ-037 SLL, din=0x00000001, shamt=4 -> done 6 cycles after start, result=0x00000010.
REQ-038 SRA, din=0x80000000, shamt=31 -> done after 33 cycles, result=0xFFFFFFFF; SRL with the same operands -> result=0x00000001.
REQ-039 SRL, din=0xDEADBEEF, shamt=0 -> LOAD then DONE, done at cycle 2, result=0xDEADBEEF.
REQ-040 ROTL, din=0x80000001, shamt=1 -> result=0x00000003.
REQ-041 Second start (din=0xFFFFFFFF) pulsed during a busy SLL of 0x1 by 2 -> ignored, result=0x00000004.
REQ-042 rst asserted during the 3rd SHIFT cycle -> next cycle busy=0, done never pulses, result=0, and sh_clear was high during the rst cycle.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the 74LS194-style shifter sequencer.
// Holds default widths, op encodings, FSM state enum, shifter mode constants
// and a helper that maps an op onto its shift direction.
package shift_ctrl_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned SHAMT_W_DEF = 5;

  // Operation encoding as seen on the op port
  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Shifter {S1,S0} mode select
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Left-going ops use SHL, right-going ops use SHR
  function automatic logic [1:0] shift_mode(input op_e op);
    return ((op == OP_SLL) || (op == OP_ROTL)) ? MODE_SHL : MODE_SHR;
  endfunction

endpackage

// File: rtl/shift_cnt.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (clears count)
//   load_i      : load val_i (has priority over dec_i)
//   dec_i       : decrement by one when nonzero
//   val_i       : load value
//   cnt_o       : current count
//   zero_o      : count equals zero
module shift_cnt
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               dec_i,
  input  logic [SHAMT_W-1:0] val_i,
  output logic [SHAMT_W-1:0] cnt_o,
  output logic               zero_o
);

  logic [SHAMT_W-1:0] cnt_q;
  logic [SHAMT_W-1:0] cnt_d;

  // Next count: load wins, decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer that drives a 74LS194-style 32-bit shift register one bit per
// cycle to implement SLL/SRL/SRA/ROTL by 0..31.
// Sequence: IDLE -(start)-> LOAD -> SHIFT x shamt -> DONE -> IDLE.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start, op, shamt,
//   din                : request and operands, sampled only in IDLE
//   busy               : high in LOAD and SHIFT
//   done               : one-cycle pulse in DONE
//   result             : last completed result; updated on the edge that
//                        ends DONE (shifter is holding its final value then)
//   sh_s1, sh_s0       : shifter mode (00 hold, 01 right, 10 left, 11 load)
//   sh_sl, sh_sr       : serial-in at bit 0 / bit WIDTH-1
//   sh_clear           : shifter clear, follows rst
//   sh_pdata           : parallel-load data, zero outside LOAD
//   sh_q               : shifter contents
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   din,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               sh_s1,
  output logic               sh_s0,
  output logic               sh_sl,
  output logic               sh_sr,
  output logic               sh_clear,
  output logic [WIDTH-1:0]   sh_pdata,
  input  logic [WIDTH-1:0]   sh_q
);

  state_e             state_q;
  op_e                op_q;
  logic [1:0]         mode_q;
  logic               sl_fb_q;
  logic               sr_fb_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   pdata_q;
  logic [WIDTH-1:0]   result_q;

  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;
  logic [SHAMT_W-1:0] cnt;
  logic               last_shift;

  // Counter takes shamt together with the other operands, so in LOAD its
  // zero flag already says whether any shifting is needed.
  assign cnt_load   = (state_q == ST_IDLE) && start;
  assign cnt_dec    = (state_q == ST_SHIFT);
  assign last_shift = (cnt == SHAMT_W'(1));

  shift_cnt #(
    .SHAMT_W (SHAMT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .val_i  (shamt),
    .cnt_o  (cnt),
    .zero_o (cnt_zero)
  );

  // FSM with outputs registered for the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SLL;
      mode_q   <= MODE_HOLD;
      sl_fb_q  <= 1'b0;
      sr_fb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pdata_q  <= '0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_LOAD;
            op_q    <= op_e'(op);
            pdata_q <= din;
            mode_q  <= MODE_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          pdata_q <= '0;
          if (cnt_zero) begin
            state_q <= ST_DONE;
            mode_q  <= MODE_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_SHIFT;
            mode_q  <= shift_mode(op_q);
            sl_fb_q <= (op_q == OP_ROTL);
            sr_fb_q <= (op_q == OP_SRA);
          end
        end
        ST_SHIFT: begin
          if (last_shift) begin
            state_q <= ST_DONE;
            mode_q  <= MODE_HOLD;
            sl_fb_q <= 1'b0;
            sr_fb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          result_q <= sh_q;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Serial-in must track the live MSB each shift, so only the enable is registered
  assign sh_sl    = sl_fb_q & sh_q[WIDTH-1];
  assign sh_sr    = sr_fb_q & sh_q[WIDTH-1];
  assign sh_s1    = mode_q[1];
  assign sh_s0    = mode_q[0];
  assign sh_pdata = pdata_q;
  assign sh_clear = rst;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule
